// File: rtl/coleco_vdp_pkg.sv
// rtl/coleco_vdp_pkg.sv - shared constants and types for the VDP CPU port
package coleco_vdp_pkg;

  localparam logic [7:0] VDP_DATA_PORT = 8'hBE;
  localparam logic [7:0] VDP_CTRL_PORT = 8'hBF;

  localparam logic [1:0] CMD_RSETUP = 2'b00;
  localparam logic [1:0] CMD_WSETUP = 2'b01;

  // Status [4:0] value when no fifth-sprite event is latched
  localparam logic [4:0] FIFTH_NONE = 5'h1F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } vram_state_t;

endpackage

// File: rtl/vdp_status_reg.sv
// rtl/vdp_status_reg.sv - VDP status flags with set-over-clear priority and interrupt output
module vdp_status_reg
  import coleco_vdp_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_clr,
  input  logic       i_frame_set,
  input  logic       i_coll_set,
  input  logic       i_fifth_set,
  input  logic [4:0] i_fifth_num,
  input  logic       i_int_en,
  output logic [7:0] o_status,
  output logic       o_n_int
);

  logic [7:0] r_status;
  logic       w_fifth_take;

  // The first fifth-sprite event of a frame is kept until software reads status
  assign w_fifth_take = i_fifth_set & ~r_status[6];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_status <= {3'b000, FIFTH_NONE};
    end else begin
      if (i_frame_set)     r_status[7] <= 1'b1;
      else if (i_clr)      r_status[7] <= 1'b0;

      if (i_coll_set)      r_status[5] <= 1'b1;
      else if (i_clr)      r_status[5] <= 1'b0;

      if (w_fifth_take) begin
        r_status[6]   <= 1'b1;
        r_status[4:0] <= i_fifth_num;
      end else if (i_clr) begin
        r_status[6]   <= 1'b0;
        r_status[4:0] <= FIFTH_NONE;
      end
    end
  end

  assign o_status = r_status;
  assign o_n_int  = ~(r_status[7] & i_int_en);

endmodule

// File: rtl/vdp_cpu_port.sv
// rtl/vdp_cpu_port.sv - VDP CPU port: address/register latch, VRAM request FSM, read-ahead buffer
module vdp_cpu_port
  import coleco_vdp_pkg::*;
#(
  parameter int         ADDR_W  = 14,
  parameter logic [7:0] R1_INIT = 8'h00
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cpu_ce,
  input  logic              i_wr_stb,
  input  logic              i_rd_stb,
  input  logic              i_port_sel,
  input  logic [7:0]        i_din,
  output logic [7:0]        o_dout,
  output logic [ADDR_W-1:0] o_vram_addr,
  output logic [7:0]        o_vram_wdata,
  output logic              o_vram_we,
  output logic              o_vram_re,
  input  logic [7:0]        i_vram_rdata,
  input  logic              i_vram_ack,
  output logic [63:0]       o_regs,
  input  logic              i_frame_set,
  input  logic              i_coll_set,
  input  logic              i_fifth_set,
  input  logic [4:0]        i_fifth_num,
  output logic              o_n_int,
  output logic              o_overrun
);

  logic              r_latch_full;
  logic [7:0]        r_first_byte;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_buffer;
  logic [7:0][7:0]   r_regs;
  logic              r_overrun;
  logic              r_rd_discard;

  vram_state_t       r_state;
  vram_state_t       w_state_nx;
  logic [ADDR_W-1:0] r_req_addr;
  logic [7:0]        r_req_data;
  logic              r_pend_valid;
  vram_state_t       r_pend_op;
  logic [ADDR_W-1:0] r_pend_addr;
  logic [7:0]        r_pend_data;

  logic              w_is_ctrl;
  logic              w_is_data;
  logic              w_ctrl_wr;
  logic              w_ctrl_rd;
  logic              w_data_wr;
  logic              w_data_rd;
  logic              w_setup;
  logic [ADDR_W-1:0] w_setup_addr;
  logic [ADDR_W-1:0] w_addr_inc;
  logic              w_cmd_valid;
  vram_state_t       w_cmd_op;
  logic [ADDR_W-1:0] w_cmd_addr;
  logic [7:0]        w_cmd_data;
  logic              w_req_load_cmd;
  logic              w_req_load_pend;
  logic              w_pend_push;
  logic              w_pend_pop;
  logic              w_drop;
  logic              w_rd_done;
  logic [7:0]        w_status;

  assign w_is_ctrl = (i_port_sel == VDP_CTRL_PORT[0]);
  assign w_is_data = (i_port_sel == VDP_DATA_PORT[0]);
  assign w_ctrl_wr = i_cpu_ce & i_wr_stb & w_is_ctrl;
  assign w_ctrl_rd = i_cpu_ce & i_rd_stb & w_is_ctrl;
  assign w_data_wr = i_cpu_ce & i_wr_stb & w_is_data;
  assign w_data_rd = i_cpu_ce & i_rd_stb & w_is_data;

  assign w_setup      = w_ctrl_wr & r_latch_full &
                        ((i_din[7:6] == CMD_RSETUP) | (i_din[7:6] == CMD_WSETUP));
  assign w_setup_addr = ADDR_W'({i_din[5:0], r_first_byte});
  assign w_addr_inc   = r_addr + ADDR_W'(1);
  assign w_rd_done    = (r_state == RD) & i_vram_ack;

  // At most one VRAM command can originate from a single CPU strobe
  always_comb begin
    w_cmd_valid = 1'b0;
    w_cmd_op    = RD;
    w_cmd_addr  = w_setup_addr;
    w_cmd_data  = i_din;
    if (w_setup && (i_din[7:6] == CMD_RSETUP)) begin
      w_cmd_valid = 1'b1;
    end else if (w_data_wr) begin
      w_cmd_valid = 1'b1;
      w_cmd_op    = WR;
      w_cmd_addr  = r_addr;
    end else if (w_data_rd) begin
      w_cmd_valid = 1'b1;
      w_cmd_addr  = w_addr_inc;
    end
  end

  always_comb begin
    w_state_nx      = r_state;
    w_req_load_cmd  = 1'b0;
    w_req_load_pend = 1'b0;
    w_pend_push     = 1'b0;
    w_pend_pop      = 1'b0;
    w_drop          = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cmd_valid) begin
          w_state_nx     = w_cmd_op;
          w_req_load_cmd = 1'b1;
        end
      end
      default: begin
        if (i_vram_ack) begin
          if (r_pend_valid) begin
            w_state_nx      = r_pend_op;
            w_req_load_pend = 1'b1;
            w_pend_pop      = 1'b1;
            w_pend_push     = w_cmd_valid;
          end else if (w_cmd_valid) begin
            w_state_nx     = w_cmd_op;
            w_req_load_cmd = 1'b1;
          end else begin
            w_state_nx = IDLE;
          end
        end else if (w_cmd_valid) begin
          w_drop      = r_pend_valid;
          w_pend_push = ~r_pend_valid;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_nx;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_req_addr   <= '0;
      r_req_data   <= 8'h00;
      r_pend_valid <= 1'b0;
      r_pend_op    <= IDLE;
      r_pend_addr  <= '0;
      r_pend_data  <= 8'h00;
    end else begin
      if (w_req_load_cmd) begin
        r_req_addr <= w_cmd_addr;
        r_req_data <= w_cmd_data;
      end else if (w_req_load_pend) begin
        r_req_addr <= r_pend_addr;
        r_req_data <= r_pend_data;
      end
      if (w_pend_push) begin
        r_pend_valid <= 1'b1;
        r_pend_op    <= w_cmd_op;
        r_pend_addr  <= w_cmd_addr;
        r_pend_data  <= w_cmd_data;
      end else if (w_pend_pop) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_latch_full <= 1'b0;
      r_first_byte <= 8'h00;
      r_addr       <= '0;
      r_buffer     <= 8'h00;
      r_regs       <= {48'h0, R1_INIT, 8'h00};
      r_overrun    <= 1'b0;
      r_rd_discard <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        if (!r_latch_full) begin
          r_first_byte <= i_din;
          r_latch_full <= 1'b1;
        end else begin
          r_latch_full <= 1'b0;
          if (i_din[7]) r_regs[i_din[2:0]] <= r_first_byte;
          else          r_addr <= w_setup_addr;
        end
      end
      if (w_data_wr || w_data_rd || w_ctrl_rd) r_latch_full <= 1'b0;
      if (w_data_wr || w_data_rd)              r_addr <= w_addr_inc;

      // A CPU write supersedes whatever the in-flight read would return
      if (w_data_wr)                      r_buffer <= i_din;
      else if (w_rd_done && !r_rd_discard) r_buffer <= i_vram_rdata;

      if (w_rd_done)                          r_rd_discard <= 1'b0;
      else if (w_data_wr && (r_state == RD))  r_rd_discard <= 1'b1;

      if (w_drop) r_overrun <= 1'b1;
    end
  end

  vdp_status_reg u_status (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_clr       (w_ctrl_rd),
    .i_frame_set (i_frame_set),
    .i_coll_set  (i_coll_set),
    .i_fifth_set (i_fifth_set),
    .i_fifth_num (i_fifth_num),
    .i_int_en    (r_regs[1][5]),
    .o_status    (w_status),
    .o_n_int     (o_n_int)
  );

  assign o_dout       = w_is_ctrl ? w_status : r_buffer;
  assign o_vram_addr  = r_req_addr;
  assign o_vram_wdata = r_req_data;
  assign o_vram_we    = (r_state == WR);
  assign o_vram_re    = (r_state == RD);
  assign o_regs       = r_regs;
  assign o_overrun    = r_overrun;

endmodule
